// File: rtl/rtc_bus_sequencer.sv
// -----------------------------------------------------------------------------
// rtc_bus_sequencer
//
// Purpose:
//   Runs one multiplexed address/data bus cycle to the external RTC chip per
//   accepted request: an address phase (address driven, WR strobed), a gap,
//   then a data phase (write data driven with WR strobed, or pins released
//   with RD strobed and the chip's data captured). Every phase has a
//   setup / strobe-width / hold timing set by parameters, so the processor
//   side only sees a request/response handshake.
//
// Ports:
//   clk        system clock
//   reset      synchronous reset, active low
//   req_valid  request strobe; accepted when req_valid & req_ready
//   req_write  1 = write transaction, 0 = read transaction
//   req_addr   RTC register address
//   req_wdata  write data
//   req_ready  high only while idle
//   rsp_valid  one-cycle pulse in the final (DONE) cycle of a transaction
//   rsp_rdata  last read data; held until the next read completes
//   CS         chip select, active low
//   AD         0 = address phase, 1 = data phase
//   RD         read strobe, active low
//   WR         write strobe, active low
//   bus_out    value for the top level to drive onto the RTC data pins
//   bus_oe     1 = top level drives bus_out onto the pins, 0 = Hi-Z
//   bus_in     value currently on the RTC data pins
//
// All outputs come straight from flops; none depends combinationally on the
// request inputs.
// -----------------------------------------------------------------------------
module rtc_bus_sequencer #(
    parameter int T_SU  = 2,  // setup cycles before each strobe
    parameter int T_PW  = 4,  // strobe low width in cycles
    parameter int T_HD  = 2,  // hold cycles after each strobe
    parameter int T_GAP = 2   // cycles between address and data phase
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       req_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       CS,
    output logic       AD,
    output logic       RD,
    output logic       WR,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    input  logic [7:0] bus_in
);

    // The phase counter is 4 bits wide, so every timing must fit in 1..15.
    if (T_SU < 1 || T_SU > 15 || T_PW < 1 || T_PW > 15 ||
        T_HD < 1 || T_HD > 15 || T_GAP < 1 || T_GAP > 15) begin : g_bad_timing
        $fatal(1, "rtc_bus_sequencer: timing parameters must be in 1..15");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_A_SU,
        S_A_PW,
        S_A_HD,
        S_GAP,
        S_D_SU,
        S_D_PW,
        S_D_HD,
        S_DONE
    } state_e;

    // Counter load value on entry to a state (its length minus one).
    function automatic logic [3:0] phase_len_m1(input state_e s);
        case (s)
            S_A_SU, S_D_SU: return 4'(T_SU - 1);
            S_A_PW, S_D_PW: return 4'(T_PW - 1);
            S_A_HD, S_D_HD: return 4'(T_HD - 1);
            S_GAP:          return 4'(T_GAP - 1);
            default:        return 4'd0;
        endcase
    endfunction

    // Fixed phase order once a transaction has started.
    function automatic state_e next_phase(input state_e s);
        case (s)
            S_A_SU:  return S_A_PW;
            S_A_PW:  return S_A_HD;
            S_A_HD:  return S_GAP;
            S_GAP:   return S_D_SU;
            S_D_SU:  return S_D_PW;
            S_D_PW:  return S_D_HD;
            S_D_HD:  return S_DONE;
            default: return S_IDLE;
        endcase
    endfunction

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       write_q, write_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;

    logic       cs_q, cs_d;
    logic       ad_q, ad_d;
    logic       rd_q, rd_d;
    logic       wr_q, wr_d;
    logic       bus_oe_q, bus_oe_d;
    logic [7:0] bus_out_q, bus_out_d;
    logic       req_ready_q, req_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;

    logic       addr_phase;
    logic       data_phase;

    // Next-state logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        if (state_q == S_IDLE) begin
            if (req_valid) begin
                state_d = S_A_SU;
                cnt_d   = phase_len_m1(S_A_SU);
                write_d = req_write;
                addr_d  = req_addr;
                wdata_d = req_wdata;
            end
        end else if (cnt_q == 4'd0) begin
            state_d = next_phase(state_q);
            cnt_d   = phase_len_m1(next_phase(state_q));
        end else begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Pin values are decoded from the state being entered, then registered,
    // so each pin changes on the same edge as the state it belongs to.
    always_comb begin
        addr_phase = (state_d == S_A_SU) || (state_d == S_A_PW) || (state_d == S_A_HD);
        data_phase = (state_d == S_D_SU) || (state_d == S_D_PW) || (state_d == S_D_HD);

        cs_d        = !(addr_phase || (state_d == S_GAP) || data_phase);
        ad_d        = (state_d == S_GAP) || data_phase || (state_d == S_DONE);
        wr_d        = !((state_d == S_A_PW) || ((state_d == S_D_PW) && write_d));
        rd_d        = !((state_d == S_D_PW) && !write_d);
        // bus_oe covers every cycle WR is low, so no turnaround under a strobe.
        bus_oe_d    = addr_phase || (data_phase && write_d);
        bus_out_d   = addr_phase ? addr_d : ((data_phase && write_d) ? wdata_d : 8'h00);
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_DONE);

        // Capture at the end of the read strobe, while the chip still drives.
        if ((state_q == S_D_PW) && (cnt_q == 4'd0) && !write_q) begin
            rsp_rdata_d = bus_in;
        end else begin
            rsp_rdata_d = rsp_rdata_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            // NOTE: the latched request is reset too; it is tiny and keeps bus_out deterministic.
            write_q     <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            cs_q        <= 1'b1;
            ad_q        <= 1'b0;
            rd_q        <= 1'b1;
            wr_q        <= 1'b1;
            bus_oe_q    <= 1'b0;
            bus_out_q   <= 8'h00;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cs_q        <= cs_d;
            ad_q        <= ad_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            bus_oe_q    <= bus_oe_d;
            bus_out_q   <= bus_out_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign CS        = cs_q;
    assign AD        = ad_q;
    assign RD        = rd_q;
    assign WR        = wr_q;
    assign bus_oe    = bus_oe_q;
    assign bus_out   = bus_out_q;
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rtc_bus_sequencer
//
// Two sequencers share one stimulus stream: dut0 with default timing and
// dut1 with every timing parameter at 1. A transaction-level model tracks,
// per DUT, how many cycles have elapsed since the accept edge and derives
// every pin from the phase boundaries of that timeline. Directed scenarios
// pin the model with hand-computed cycle numbers; a random phase follows.
// -----------------------------------------------------------------------------
module tb_rtc_bus_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       req_valid;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic [7:0] bus_in;

    logic       rr_o  [2];
    logic       rv_o  [2];
    logic [7:0] rdat_o[2];
    logic       cs_o  [2];
    logic       ad_o  [2];
    logic       rd_o  [2];
    logic       wr_o  [2];
    logic [7:0] bo_o  [2];
    logic       oe_o  [2];

    rtc_bus_sequencer u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(rr_o[0]), .rsp_valid(rv_o[0]), .rsp_rdata(rdat_o[0]),
        .CS(cs_o[0]), .AD(ad_o[0]), .RD(rd_o[0]), .WR(wr_o[0]),
        .bus_out(bo_o[0]), .bus_oe(oe_o[0]), .bus_in(bus_in)
    );

    rtc_bus_sequencer #(.T_SU(1), .T_PW(1), .T_HD(1), .T_GAP(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(rr_o[1]), .rsp_valid(rv_o[1]), .rsp_rdata(rdat_o[1]),
        .CS(cs_o[1]), .AD(ad_o[1]), .RD(rd_o[1]), .WR(wr_o[1]),
        .bus_out(bo_o[1]), .bus_oe(oe_o[1]), .bus_in(bus_in)
    );

    // Timing of each DUT.
    int su [2] = '{2, 1};
    int pw [2] = '{4, 1};
    int hd [2] = '{2, 1};
    int gp [2] = '{2, 1};

    // Transaction model: busy flag, cycle index since accept (1 = first
    // cycle after the accept edge), the latched request, last read data.
    bit         m_busy [2];
    int         m_t    [2];
    bit         m_write[2];
    logic [7:0] m_addr [2];
    logic [7:0] m_wdata[2];
    logic [7:0] m_rdata[2] = '{8'h00, 8'h00};

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Compare every output of both DUTs with the model for the current cycle.
    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            int a1, a2, a3, g, d1, d2, d3, dn, t;
            bit b, w, strobe_a, strobe_d;
            bit e_cs, e_ad, e_wr, e_rd, e_oe, e_rv, e_rr;
            string p;
            a1 = su[k];  a2 = a1 + pw[k];  a3 = a2 + hd[k];  g  = a3 + gp[k];
            d1 = g + su[k];  d2 = d1 + pw[k];  d3 = d2 + hd[k];  dn = d3 + 1;
            b = m_busy[k];  t = m_t[k];  w = m_write[k];
            strobe_a = b && t > a1 && t <= a2;
            strobe_d = b && t > d1 && t <= d2;
            e_cs = !(b && t <= d3);
            e_ad = b && t > a3;
            e_wr = !(strobe_a || (w && strobe_d));
            e_rd = !(!w && strobe_d);
            e_oe = (b && t <= a3) || (b && w && t > g && t <= d3);
            e_rv = b && t == dn;
            e_rr = !b;
            p = $sformatf("dut%0d c%0d ", k, cyc);
            check({p, "CS"},        32'(cs_o[k]),   32'(e_cs));
            check({p, "AD"},        32'(ad_o[k]),   32'(e_ad));
            check({p, "WR"},        32'(wr_o[k]),   32'(e_wr));
            check({p, "RD"},        32'(rd_o[k]),   32'(e_rd));
            check({p, "bus_oe"},    32'(oe_o[k]),   32'(e_oe));
            check({p, "rsp_valid"}, 32'(rv_o[k]),   32'(e_rv));
            check({p, "req_ready"}, 32'(rr_o[k]),   32'(e_rr));
            check({p, "rsp_rdata"}, 32'(rdat_o[k]), 32'(m_rdata[k]));
            if (e_oe) check({p, "bus_out"}, 32'(bo_o[k]), 32'(t <= a3 ? m_addr[k] : m_wdata[k]));
            // Protocol rules, checked on the DUT pins directly.
            check({p, "proto_wr_oe"}, 32'(wr_o[k] == 1'b0 ? oe_o[k] : 1'b1), 32'd1);
            check({p, "proto_rd_wr"}, 32'(rd_o[k] | wr_o[k]), 32'd1);
            check({p, "proto_cs"},    32'((rd_o[k] & wr_o[k]) ? 1'b0 : cs_o[k]), 32'd0);
        end
    endtask

    // Advance the model across the coming edge using the inputs now applied.
    task automatic model_advance();
        for (int k = 0; k < 2; k++) begin
            int d2, dn;
            d2 = 2 * su[k] + pw[k] + hd[k] + gp[k] + pw[k];
            dn = d2 + hd[k] + 1;
            if (!reset) begin
                m_busy[k]  = 1'b0;
                m_t[k]     = 0;
                m_rdata[k] = 8'h00;
            end else if (m_busy[k]) begin
                if (!m_write[k] && m_t[k] == d2) m_rdata[k] = bus_in;
                if (m_t[k] == dn) m_busy[k] = 1'b0;
                else m_t[k]++;
            end else if (req_valid) begin
                m_busy[k]  = 1'b1;
                m_t[k]     = 1;
                m_write[k] = req_write;
                m_addr[k]  = req_addr;
                m_wdata[k] = req_wdata;
            end
        end
    endtask

    // Apply inputs for the current cycle, cross one edge, then compare.
    task automatic tick(input bit rv, input bit rw, input logic [7:0] ra,
                        input logic [7:0] rwd, input logic [7:0] bi, input bit rst_n);
        reset     = rst_n;
        req_valid = rv;
        req_write = rw;
        req_addr  = ra;
        req_wdata = rwd;
        bus_in    = bi;
        model_advance();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    initial begin
        // Reset.
        tick(0, 0, 8'h00, 8'h00, 8'h00, 0);
        tick(0, 0, 8'h00, 8'h00, 8'h00, 0);
        check("reset CS", 32'(cs_o[0]), 32'd1);
        check("reset req_ready", 32'(rr_o[0]), 32'd1);
        tick(0, 0, 8'h00, 8'h00, 8'h00, 1);

        // Write 0x59 to register 0x21, default timing.
        cyc = 0;
        tick(1, 1, 8'h21, 8'h59, 8'h00, 1);
        for (int c = 1; c <= 20; c++) begin
            if (cyc == 3) begin
                check("wr addr WR", 32'(wr_o[0]), 32'd0);
                check("wr addr bus_out", 32'(bo_o[0]), 32'h21);
                check("wr addr AD", 32'(ad_o[0]), 32'd0);
            end
            if (cyc == 13) begin
                check("wr data WR", 32'(wr_o[0]), 32'd0);
                check("wr data bus_out", 32'(bo_o[0]), 32'h59);
                check("wr data AD", 32'(ad_o[0]), 32'd1);
            end
            if (cyc <= 18) check("wr CS low", 32'(cs_o[0]), 32'd0);
            check("wr RD high", 32'(rd_o[0]), 32'd1);
            if (cyc == 19) check("wr rsp_valid", 32'(rv_o[0]), 32'd1);
            if (cyc == 20) check("wr req_ready back", 32'(rr_o[0]), 32'd1);
            tick(0, 0, 8'h00, 8'h00, 8'h00, 1);
        end

        // Read register 0x22 with the chip returning 0x37.
        cyc = 0;
        tick(1, 0, 8'h22, 8'h00, 8'h37, 1);
        for (int c = 1; c <= 20; c++) begin
            if (cyc >= 13 && cyc <= 16) check("rd RD low", 32'(rd_o[0]), 32'd0);
            if (cyc == 12 || cyc == 17) check("rd RD edge", 32'(rd_o[0]), 32'd1);
            if (cyc >= 9 && cyc <= 19) check("rd bus_oe off", 32'(oe_o[0]), 32'd0);
            if (cyc == 19) begin
                check("rd rsp_valid", 32'(rv_o[0]), 32'd1);
                check("rd rsp_rdata", 32'(rdat_o[0]), 32'h37);
            end
            if (cyc == 6) check("fast RD low", 32'(rd_o[1]), 32'd0);
            if (cyc == 5 || cyc == 7) check("fast RD high", 32'(rd_o[1]), 32'd1);
            if (cyc == 8) check("fast rsp_valid", 32'(rv_o[1]), 32'd1);
            tick(0, 0, 8'h00, 8'h00, 8'h37, 1);
        end

        // Back-to-back: req_valid held, write then read.
        cyc = 0;
        while (cyc < 41) begin
            tick(cyc <= 20, cyc == 0, (cyc == 0) ? 8'h40 : 8'h41, 8'hA5, 8'($urandom), 1);
            if (cyc >= 1 && cyc <= 19) check("b2b req_ready low", 32'(rr_o[0]), 32'd0);
            if (cyc == 20) check("b2b req_ready idle", 32'(rr_o[0]), 32'd1);
            if (cyc == 21) check("b2b second accept", 32'(rr_o[0]), 32'd0);
            if (cyc == 19 || cyc == 39) check("b2b rsp_valid", 32'(rv_o[0]), 32'd1);
        end

        // Reset in the middle of a write's data strobe.
        cyc = 0;
        tick(1, 1, 8'h5A, 8'h3C, 8'h00, 1);
        while (cyc < 14) tick(0, 0, 8'h00, 8'h00, 8'h00, 1);
        check("mid WR low before reset", 32'(wr_o[0]), 32'd0);
        tick(0, 0, 8'h00, 8'h00, 8'h00, 0);
        check("mid WR", 32'(wr_o[0]), 32'd1);
        check("mid CS", 32'(cs_o[0]), 32'd1);
        check("mid bus_oe", 32'(oe_o[0]), 32'd0);
        check("mid req_ready", 32'(rr_o[0]), 32'd1);
        repeat (12) begin
            tick(0, 0, 8'h00, 8'h00, 8'h00, 1);
            check("mid no rsp_valid", 32'(rv_o[0]), 32'd0);
        end

        // Random traffic, including occasional resets.
        repeat (4000) begin
            tick($urandom_range(0, 2) == 0, 1'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), $urandom_range(0, 499) != 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
- Sequences multiplexed address/data bus cycles to the external RTC chip: a register address phase, then a data read or write phase.
- Drives the chip-select, address/data-select, read and write strobes with programmable phase timing.
- Sits between the port-mapped RTC register logic, which issues single-transaction requests, and the top-level tristate RTC pins.
- Owns all RTC pin timing so the processor side only performs a request/response handshake.

Parameters:
- T_SU, 2: setup cycles before each strobe; range 1..15.
- T_PW, 4: strobe low width in cycles; range 1..15.
- T_HD, 2: hold cycles after each strobe; range 1..15.
- T_GAP, 2: cycles between address phase and data phase; range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  transaction request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  8  RTC register address
- req_wdata  in  8  write data
- req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready
- rsp_valid  out  1  one-cycle pulse at transaction end
- rsp_rdata  out  8  read data; held until the next read completes
- CS  out  1  chip select, active low
- AD  out  1  0 = address phase, 1 = data phase
- RD  out  1  read strobe, active low
- WR  out  1  write strobe, active low
- bus_out  out  8  value driven on the RTC data pins
- bus_oe  out  1  1 = top level drives the pins with bus_out; 0 = Hi-Z
- bus_in  in  8  RTC pin input value

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low: sampled on the rising edge of clk when reset = 0.
- Reset values:
  - CS = 1, AD = 0, RD = 1, WR = 1.
  - bus_oe = 0, bus_out = 0.
  - req_ready = 1, rsp_valid = 0, rsp_rdata = 0.
  - State = IDLE, phase counter = 0.
- Outputs: all outputs are registered; there is no combinational path from request inputs to pins.
- Accept: on an edge where state = IDLE and req_valid = 1:
  - latch addr, wdata and write into internal registers;
  - next state is A_SU; req_ready drops the following cycle.
- State sequence: IDLE → A_SU(T_SU) → A_PW(T_PW) → A_HD(T_HD) → GAP(T_GAP) → D_SU(T_SU) → D_PW(T_PW) → D_HD(T_HD) → DONE(1) → IDLE.
- Phase counter: 4 bits. Loaded with N−1 on state entry, decremented each cycle; the state advances when it reaches 0.
- Pin values per state:
  - CS: 0 in A_SU..D_HD inclusive, including GAP; 1 in IDLE and DONE.
  - AD: 0 in IDLE and A_*; 1 in GAP, D_* and DONE; returns to 0 in IDLE.
  - WR: 0 in A_PW; 0 in D_PW if write; 1 otherwise.
  - RD: 0 in D_PW if read; 1 otherwise.
  - bus_oe and bus_out:
    - A_*: bus_oe = 1, bus_out = latched addr.
    - D_* on a write: bus_oe = 1, bus_out = latched wdata.
    - GAP, read data phase, IDLE and DONE: bus_oe = 0.
    - WR and bus_oe are never low and 0 together, so no bus turnaround occurs under a write strobe.
- Read capture: rsp_rdata <= bus_in on the last D_PW cycle (counter = 0) of a read. Writes leave rsp_rdata unchanged.
- Latency with defaults: accept edge = cycle 0.
  - A_SU = cycles 1–2, A_PW = 3–6, A_HD = 7–8, GAP = 9–10.
  - D_SU = 11–12, D_PW = 13–16, D_HD = 17–18.
  - DONE = cycle 19 with rsp_valid = 1; req_ready = 1 again from cycle 20.
  - General formula: DONE at cycle 2·(T_SU + T_PW + T_HD) + T_GAP + 1.
- Back-to-back: a req_valid held high is accepted on the first IDLE edge. The minimum spacing between accepts is total + 1 cycles.
- req_valid outside IDLE: ignored, no queuing. Request inputs may change freely after accept.
- Reset mid-transaction: the next edge forces all reset values. No rsp_valid is issued, and CS/RD/WR return high immediately.
- Out-of-range parameters (0 or >15): unsupported; the implementation must fail elaboration via a generate-time check.

Test Plan:
- Write, default params: req addr 0x21, wdata 0x59, write = 1.
  - WR low cycles 3–6 with bus_out 0x21, AD = 0.
  - WR low cycles 13–16 with bus_out 0x59, AD = 1.
  - RD stays 1; CS low cycles 1–18; rsp_valid only at cycle 19.
- Read, default params: addr 0x22, bus_in = 0x37 during D_PW.
  - RD low cycles 13–16; bus_oe = 0 cycles 9–19.
  - rsp_rdata = 0x37 at cycle 19 with rsp_valid.
- Back-to-back: req_valid held high with two queued requests (write, then read).
  - Second accept at cycle 20; second rsp_valid at cycle 39.
  - req_ready = 0 in cycles 1–19.
- Reset mid-operation: drive reset = 0 at cycle 14 of a write.
  - Next edge: WR = 1, CS = 1, bus_oe = 0, req_ready = 1.
  - No rsp_valid follows.
- Timing params T_SU=1, T_PW=1, T_HD=1, T_GAP=1 on a read:
  - rsp_valid at cycle 8;
  - RD low exactly one cycle (cycle 6).
- Protocol checker, random transactions: assert bus_oe = 1 whenever WR = 0; assert RD and WR are never low together; assert CS = 0 whenever either strobe is low.
